// File: rtl/regfile_blk_wr_if.sv
// Write/read bus for the register file: single-write channel, block-transfer sequencer
// controls and the two read ports.
interface regfile_blk_wr_if #(
    parameter int DATA_W = 32
);
    logic              i_wr_valid;
    logic              o_wr_ready;
    logic [3:0]        i_wr_sel;
    logic [DATA_W-1:0] i_wr_data;
    logic              i_blk_start;
    logic [15:0]       i_blk_list;
    logic              o_blk_busy;
    logic [3:0]        o_blk_sel;
    logic              o_blk_done;
    logic [15:0]       o_wr_en;
    logic [3:0]        i_rd_a_sel;
    logic [3:0]        i_rd_b_sel;
    logic [DATA_W-1:0] o_rd_a;
    logic [DATA_W-1:0] o_rd_b;

    modport master (
        output i_wr_valid, i_wr_sel, i_wr_data, i_blk_start, i_blk_list,
               i_rd_a_sel, i_rd_b_sel,
        input  o_wr_ready, o_blk_busy, o_blk_sel, o_blk_done, o_wr_en,
               o_rd_a, o_rd_b
    );

    modport slave (
        input  i_wr_valid, i_wr_sel, i_wr_data, i_blk_start, i_blk_list,
               i_rd_a_sel, i_rd_b_sel,
        output o_wr_ready, o_blk_busy, o_blk_sel, o_blk_done, o_wr_en,
               o_rd_a, o_rd_b
    );
endinterface

// File: rtl/regfile_blk_wr.sv
// 16 x DATA_W register file, two bypassed combinational read ports, one write port,
// with an LDM-style block sequencer that writes one listed register per accepted beat.
//
// state | meaning
// IDLE  | single writes via i_wr_sel; i_blk_start loads the register list
// BLOCK | each accepted beat writes the lowest pending register and clears its bit
module regfile_blk_wr #(
    parameter int DATA_W = 32
) (
    input  logic              i_clk,
    input  logic              i_rst,
    regfile_blk_wr_if.slave   bus
);

    typedef enum logic {
        IDLE  = 1'b0,
        BLOCK = 1'b1
    } state_t;

    state_t            state_q;
    logic [15:0]       pending_q;
    logic [15:0]       pending_d;
    logic              done_q;
    logic [DATA_W-1:0] regs_q [16];

    logic              wr_ready;
    logic              wr_accept;
    logic [3:0]        blk_sel;
    logic [3:0]        wr_target;
    logic [15:0]       wr_en;

    // Lowest set pending bit wins; pending is all-zero in IDLE so this yields 0 there.
    always_comb begin
        blk_sel = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (pending_q[i]) begin
                blk_sel = 4'(i);
            end
        end
    end

    always_comb begin
        wr_ready  = (state_q == BLOCK) ? 1'b1 : !bus.i_blk_start;
        wr_accept = bus.i_wr_valid && wr_ready;
        wr_target = (state_q == BLOCK) ? blk_sel : bus.i_wr_sel;
        wr_en     = wr_accept ? (16'h0001 << wr_target) : 16'h0000;
        pending_d = pending_q & ~wr_en;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= IDLE;
            pending_q <= 16'h0000;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.i_blk_start) begin
                        if (bus.i_blk_list != 16'h0000) begin
                            pending_q <= bus.i_blk_list;
                            state_q   <= BLOCK;
                        end else begin
                            done_q <= 1'b1;
                        end
                    end
                end
                BLOCK: begin
                    if (wr_accept) begin
                        pending_q <= pending_d;
                        if (pending_d == 16'h0000) begin
                            state_q <= IDLE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    pending_q <= 16'h0000;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        for (int i = 0; i < 16; i++) begin
            if (i_rst) begin
                regs_q[i] <= '0;
            end else if (wr_en[i]) begin
                regs_q[i] <= bus.i_wr_data;
            end
        end
    end

    // Each read port bypasses independently when the accepted beat targets its address.
    always_comb begin
        bus.o_rd_a = (wr_accept && (wr_target == bus.i_rd_a_sel)) ? bus.i_wr_data
                                                                   : regs_q[bus.i_rd_a_sel];
        bus.o_rd_b = (wr_accept && (wr_target == bus.i_rd_b_sel)) ? bus.i_wr_data
                                                                   : regs_q[bus.i_rd_b_sel];
    end

    assign bus.o_wr_ready = wr_ready;
    assign bus.o_wr_en    = wr_en;
    assign bus.o_blk_sel  = blk_sel;
    assign bus.o_blk_busy = (state_q == BLOCK);
    assign bus.o_blk_done = done_q;

endmodule
